lsu: RTL
========

// Module: lsu
// PURPOSE
//  Load/store unit directly downstream of the execution unit. Takes mem_opcode, address (ALU result)
//  and store data (rs2) for one memory op and runs it on the data bus with a req/gnt/rvalid handshake.
//  Returns aligned, sign/zero-extended load data for rd write-back. Holds req_ready low while busy.
// PARAMETERS
//  XLEN     32  data/address width; only 32 is supported (dbus_strb is XLEN/8 bits)
//  MEMOP_W  3   mem_opcode width; encoding = RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101)
// PORTS
//  clk            in   1        clock; single clock domain
//  rst_b          in   1        asynchronous active-low reset
//  req_valid      in   1        upstream memory op valid
//  req_ready      out  1        LSU can accept an op (1 only in IDLE)
//  req_read       in   1        op is a load
//  req_write      in   1        op is a store
//  mem_opcode     in   MEMOP_W  size/sign, funct3 encoding
//  addr           in   XLEN     byte address
//  wdata          in   XLEN     store data, right-justified
//  resp_valid     out  1        1-cycle pulse: op complete
//  resp_rdata     out  XLEN     extended load data; 0 for stores
//  resp_misalign  out  1        misaligned op aborted (only with LSU_MISALIGN_CHECK_EN; else tied 0)
//  dbus_req       out  1        bus request
//  dbus_we        out  1        1=write
//  dbus_addr      out  XLEN     word-aligned address ({addr[XLEN-1:2],2'b00})
//  dbus_wdata     out  XLEN     lane-replicated store data
//  dbus_strb      out  XLEN/8   byte strobes
//  dbus_gnt       in   1        bus accepts request
//  dbus_rvalid    in   1        response/write-ack; never in the same cycle as its gnt
//  dbus_rdata     in   XLEN     read data, full word
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_misalign=0; dbus_req=0, dbus_we=0,
//   dbus_addr/wdata/strb=0. Async reset mid-op aborts immediately; a later stale rvalid is ignored in IDLE.
//  FSM IDLE->REQ->WAIT->IDLE:
//   IDLE: accept on req_valid & (req_read|req_write); latch opcode, addr, wdata, we; -> REQ.
//         req_valid with neither read nor write: ignored, no state change. read&write both 1: treated as store.
//   REQ : dbus_req=1; addr/we/wdata/strb held stable until dbus_gnt; on gnt -> WAIT (dbus_req drops next cycle).
//   WAIT: on dbus_rvalid: resp_valid=1 for exactly one cycle with resp_rdata; -> IDLE.
//  Latency: accept edge -> resp_valid >= 3 cycles (gnt in 1st REQ cycle, rvalid next cycle).
//  Back-to-back: new op accepted in the cycle after resp_valid.
//  Store lanes: SB strb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH strb=4'b0011<<{addr[1],1'b0},
//   wdata={2{wdata[15:0]}}; SW strb=4'hF, wdata unchanged.
//  Loads: word=dbus_rdata>>(8*addr[1:0]) (SH/LH lanes use addr[1] only); LB/LH sign-extend,
//   LBU/LHU zero-extend, LW unchanged. Extracted from latched addr, not live input.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is detected at accept;
//   no bus request; resp_valid with resp_misalign=1, resp_rdata=0 one cycle after accept; back to IDLE.
//  Not defined: no check; resp_misalign tied 0; low address bits select lanes as above (word ops use full word,
//   halfword at offset 3 uses lanes 2-3), i.e. silently truncated to the naturally aligned container.
// STRUCTURE
//  Shared package core_pkg: MEMOP_* funct3 localparams, lsu_state_t enum {IDLE,REQ,WAIT}.
//  Sub-module lsu_load_align: combinational shift + sign/zero extension (opcode, addr[1:0], rdata -> result).
//  Top lsu: FSM, request latch, store lane/strobe generation.
// TESTING
//  LW addr 0x100, rdata 0xDEADBEEF, gnt 1st cycle -> resp_rdata 0xDEADBEEF, resp_valid 3 cycles after accept.
//  LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
//  SB addr 0x201, wdata 0x000000A5 -> dbus_we=1, strb 4'b0010, dbus_wdata 0xA5A5A5A5, dbus_addr 0x200.
//  gnt delayed 5 cycles -> dbus_req/addr/strb stable all 5 cycles, req_ready=0 throughout, single resp pulse.
//  rst_b low in WAIT -> outputs at reset values same cycle; rvalid after release -> no resp_valid.
//  With LSU_MISALIGN_CHECK_EN: LW addr 0x102 -> no dbus_req, resp_misalign=1 next cycle; without: normal LW at 0x100.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared memory-op encodings, LSU state type and alignment helper
package core_pkg;

    localparam int XLEN    = 32;
    localparam int MEMOP_W = 3;

    // RV32 funct3 encoding; bits [1:0] give the access size, bit 2 selects zero-extension
    localparam logic [MEMOP_W-1:0] MEMOP_LB  = 3'b000;
    localparam logic [MEMOP_W-1:0] MEMOP_LH  = 3'b001;
    localparam logic [MEMOP_W-1:0] MEMOP_LW  = 3'b010;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU = 3'b100;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    function automatic logic memop_misaligned(logic [MEMOP_W-1:0] op, logic [1:0] addr_lo);
        return ((op[1:0] == 2'b01) && addr_lo[0]) || (op[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request/response and data-bus signal bundle for the load/store unit
interface lsu_if;
    import core_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_read;
    logic                req_write;
    logic [MEMOP_W-1:0]  mem_opcode;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic                resp_valid;
    logic [XLEN-1:0]     resp_rdata;
    logic                resp_misalign;
    logic                dbus_req;
    logic                dbus_we;
    logic [XLEN-1:0]     dbus_addr;
    logic [XLEN-1:0]     dbus_wdata;
    logic [XLEN/8-1:0]   dbus_strb;
    logic                dbus_gnt;
    logic                dbus_rvalid;
    logic [XLEN-1:0]     dbus_rdata;

    modport master (
        input  req_valid, req_read, req_write, mem_opcode, addr, wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_strb
    );

    modport slave (
        output req_valid, req_read, req_write, mem_opcode, addr, wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_strb
    );

endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/halfword lane of a bus word and extends it
module lsu_load_align
    import core_pkg::*;
(
    input  logic [MEMOP_W-1:0] opcode_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [XLEN-1:0]    rdata_i,
    output logic [XLEN-1:0]    result_o
);

    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;

    // halfwords ignore addr[0] so an odd offset falls back to its aligned container
    assign byte_sh = rdata_i >> {addr_lo_i, 3'b000};
    assign half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};

    always_comb begin
        result_o = rdata_i;
        case (opcode_i)
            MEMOP_LB:  result_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
            MEMOP_LBU: result_o = {24'b0, byte_sh[7:0]};
            MEMOP_LH:  result_o = {{16{half_sh[15]}}, half_sh[15:0]};
            MEMOP_LHU: result_o = {16'b0, half_sh[15:0]};
            default:   result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request latch, store lane steering, bus FSM; LSU_MISALIGN_CHECK_EN enables misalignment abort
module lsu
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    lsu_if.master bus
);

    lsu_state_t          state_q, state_d;
    logic [MEMOP_W-1:0]  op_q, op_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_mis_q, resp_mis_d;

    logic [XLEN-1:0]     load_data;
    logic [XLEN/8-1:0]   st_strb;
    logic [XLEN-1:0]     st_wdata;
    logic                misalign_hit;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign_hit = memop_misaligned(bus.mem_opcode, bus.addr[1:0]);
`else
    assign misalign_hit = 1'b0;
`endif

    lsu_load_align u_load_align (
        .opcode_i  (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (bus.dbus_rdata),
        .result_o  (load_data)
    );

    always_comb begin
        st_strb  = 4'hF;
        st_wdata = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << {addr_q[1], 1'b0};
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_mis_d    = 1'b0;
        bus.req_ready  = 1'b0;
        bus.dbus_req   = 1'b0;
        bus.dbus_we    = 1'b0;
        bus.dbus_addr  = '0;
        bus.dbus_wdata = '0;
        bus.dbus_strb  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid && (bus.req_read || bus.req_write)) begin
                    if (misalign_hit) begin
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else begin
                        op_d    = bus.mem_opcode;
                        addr_d  = bus.addr;
                        wdata_d = bus.wdata;
                        we_d    = bus.req_write;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                bus.dbus_req   = 1'b1;
                bus.dbus_we    = we_q;
                bus.dbus_addr  = {addr_q[XLEN-1:2], 2'b00};
                bus.dbus_wdata = st_wdata;
                bus.dbus_strb  = st_strb;
                if (bus.dbus_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (bus.dbus_rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : load_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_misalign = resp_mis_q;

endmodule
